// File: rtl/rr_mux_sel_if.sv
// rr_mux_sel_if: request/ack bundle and registered select outputs
// between four requesters, the arbiter and the downstream 4:1 mux.
interface rr_mux_sel_if;
  logic [3:0] req;
  logic       ack;
  logic       s0;
  logic       s1;
  logic [3:0] gnt;
  logic       valid;
  logic       timeout;

  modport master (
    input  req,
    input  ack,
    output s0,
    output s1,
    output gnt,
    output valid,
    output timeout
  );

  modport slave (
    output req,
    output ack,
    input  s0,
    input  s1,
    input  gnt,
    input  valid,
    input  timeout
  );
endinterface

// File: rtl/rr_mux_sel.sv
// rr_mux_sel: round-robin select generator for a 4:1 mux stage.
// Optional dwell timeout enabled by defining RR_MUX_SEL_TIMEOUT_EN.
module rr_mux_sel #(
  parameter int DWELL_MAX = 8
) (
  input logic          clk,
  input logic          rst,
  rr_mux_sel_if.master bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (DWELL_MAX < 2 || DWELL_MAX > 255) begin : g_bad_dwell
    $error("rr_mux_sel: DWELL_MAX out of range 2..255");
  end

  logic [0:0] state;
  logic [1:0] ptr;
  logic [7:0] cnt;
  logic [1:0] cur;
  logic [1:0] idx;
  logic [1:0] pick;
  logic       found;
  logic       rel_wd;
  logic       rel_to;
  logic       rel;
  logic       to_pulse;

  assign cur = {bus.s1, bus.s0};

  // first requester at or after ptr, wrapping mod 4
  always_comb begin
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

`ifdef RR_MUX_SEL_TIMEOUT_EN
  assign rel_to = (cnt == 8'(DWELL_MAX - 1));
`else
  assign rel_to = 1'b0;
`endif

  assign rel_wd   = ~bus.req[cur];
  assign rel      = bus.ack | rel_wd | rel_to;
  assign to_pulse = rel_to & ~bus.ack & ~rel_wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      cnt         <= 8'd0;
      bus.s0      <= 1'b0;
      bus.s1      <= 1'b0;
      bus.gnt     <= 4'b0000;
      bus.valid   <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (found) begin
            {bus.s1, bus.s0} <= pick;
            bus.gnt          <= 4'b0001 << pick;
            bus.valid        <= 1'b1;
            cnt              <= 8'd0;
            state            <= GRANT;
          end
        end
        (state == GRANT): begin
          if (cnt != 8'hff) cnt <= cnt + 8'd1;
          // selects stay on the last channel so the mux never glitches
          if (rel) begin
            bus.gnt     <= 4'b0000;
            bus.valid   <= 1'b0;
            bus.timeout <= to_pulse;
            ptr         <= cur + 2'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_mux_sel.md
# rr_mux_sel

Round-robin select generator that drives the two select lines of the 4:1 data-path multiplexer stage immediately downstream. Four requesters compete for the shared output. The block grants one at a time and holds `s1`/`s0` stable for the whole grant. It releases on consumer acknowledge, on request withdrawal, or (optionally) on a dwell timeout.

## Interface

Parameters:
- `DWELL_MAX`, default 8: maximum cycles a grant is held before forced release. Legal range 2..255. Used only when the timeout feature is compiled in.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request per channel; bit i = channel i (a=0, b=1, c=2, d=3).
- `ack`  input  1  consumer accepted the current channel's data; sampled only while `valid`=1.
- `s0`  output  1  mux select LSB, registered.
- `s1`  output  1  mux select MSB, registered; {s1,s0} = granted channel index.
- `gnt`  output  4  one-hot grant, registered; all zeros when idle.
- `valid`  output  1  high while a grant is active and the selects are stable.
- `timeout`  output  1  one-cycle pulse when a grant ends by dwell expiry.

## Operation

- Internal state: FSM {IDLE, GRANT}, 2-bit priority pointer `ptr`, 8-bit dwell counter `cnt`.
- IDLE:
  - If `req`≠0, choose the first set bit scanning `ptr`, `ptr`+1, … (mod 4).
  - Load {s1,s0} with that channel, set its `gnt` bit, set `valid`=1, clear `cnt`, go to GRANT.
  - If `req`=0, stay idle with the outputs unchanged from the last release values: `gnt`=0, `valid`=0.
- GRANT: {s1,s0} and `gnt` are frozen; `cnt` increments each cycle, saturating at 255. A release occurs at the edge on which any of the following is true:
  - `ack`=1 (normal completion);
  - `req[granted]`=0 (withdrawal);
  - timeout feature enabled and `cnt` = `DWELL_MAX`-1.
- On release:
  - `gnt`←0, `valid`←0.
  - {s1,s0} keep the last granted value; the select lines do not glitch to 0.
  - `ptr`←granted+1 mod 4.
  - Go to IDLE.
- Release priority when several conditions hold in the same cycle: ack > withdrawal > timeout. `timeout` pulses only if neither ack nor withdrawal is present.
- A channel that holds `req` continuously still loses priority after each grant. No channel waits more than 3 grants.
- Requests arriving or dropping on non-granted channels during GRANT have no effect until the next IDLE cycle.

## Timing

- Reset values, applied immediately and asynchronously: `s0`=0, `s1`=0, `gnt`=0000, `valid`=0, `timeout`=0, `ptr`=0, `cnt`=0, state IDLE.
- Request to grant: `req` sampled high at edge N gives `valid`/`gnt`/selects at edge N (registered outputs visible after edge N). Latency from request assertion is 1 cycle.
- Release: the condition sampled at edge M drops `valid` after edge M. The next grant cannot appear before edge M+1, so there is always exactly one idle bubble cycle between grants.
- Minimum grant length is 1 cycle (`ack` high on the first valid cycle).
- Timeout grant length is exactly `DWELL_MAX` cycles of `valid`=1. `timeout` is high for the one cycle immediately after the last valid cycle, concurrent with `valid`=0.
- Reset asserted mid-GRANT clears everything at once. After reset release, arbitration restarts from channel 0.

## Configuration

- `RR_MUX_SEL_TIMEOUT_EN`:
  - Defined: the dwell comparator and the `timeout` pulse are active.
  - Undefined: a grant lasts until `ack` or withdrawal, however long. `timeout` is tied to 0. `cnt` still counts (saturating) but never causes a release.

## Test plan

- Reset mid-grant: grant ch2, assert `rst` asynchronously between edges. Required: outputs go to 0 and `gnt`=0000 before the next edge; after release, `req`=1111 grants ch0 first.
- Single request: `req`=0100 at edge 1, `ack`=1 at edge 3. Required: {s1,s0}=10 and `gnt`=0100 over edges 1–3, `valid` low after edge 3, selects held at 10.
- Round-robin fairness: `req`=1111 constant, `ack` pulsed on every valid cycle. Required: grant order 0,1,2,3,0,… with one bubble between grants.
- Pointer skip: `ptr`=1 after a ch0 grant, `req`=1001. Required: ch3 granted next, then ch0.
- Simultaneous events: in the same cycle assert `ack`=1, drop `req[granted]`, and set `cnt`=`DWELL_MAX`-1 (macro defined). Required: release occurs and `timeout` stays 0.
- Dwell timeout, macro defined, `DWELL_MAX`=4: `req`=0010 held, `ack`=0. Required: `valid` high for exactly 4 cycles, then `timeout` pulses for 1 cycle. The next grant goes to ch1 again after the bubble. With the macro undefined, the same stimulus holds the grant for 300+ cycles and `timeout` stays 0.
